// File: rtl/challenge_gen_hs.sv
// challenge_gen_hs: builds N_CB-bit challenges from N_RNG TRNG streams with a valid/ready
// handshake, optional per-channel decorrelation and sticky stuck-bit health flags.
module challenge_gen_hs #(
    parameter int N_CB      = 64,
    parameter int N_RNG     = 4,
    parameter int MODE      = 0,
    parameter int STUCK_LIM = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_RNG-1:0] rand_in,
    input  logic             start,
    input  logic             c_ready,
    output logic [N_CB-1:0]  C,
    output logic             c_valid,
    output logic             c_err,
    output logic             busy,
    output logic [N_RNG-1:0] fail
);
    localparam int W  = N_CB / N_RNG;
    localparam int CW = W > 1 ? $clog2(W) : 1;
    localparam int RW = $clog2(STUCK_LIM + 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [N_RNG-1:0] rand_q;
    logic [N_RNG-1:0] bits;
    logic [N_RNG-1:0] fail_nx;
    logic [RW-1:0]    run [N_RNG];
    logic [RW-1:0]    run_nx [N_RNG];
    logic [N_CB-1:0]  c_shift;

    assign bits = (MODE != 0) ? rand_in ^ rand_q : rand_in;

    // Newest bits enter at the top so the first fill lands in the least significant slot.
    generate
        if (N_CB == N_RNG) begin : g_one
            assign c_shift = bits;
        end else begin : g_many
            assign c_shift = {bits, C[N_CB-1:N_RNG]};
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < N_RNG; k++) begin
            run_nx[k] = rand_in[k] != rand_q[k] ? '0 :
                        run[k] == RW'(STUCK_LIM) ? run[k] : run[k] + RW'(1);
            fail_nx[k] = fail[k] | (run_nx[k] == RW'(STUCK_LIM));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            C       <= '0;
            c_valid <= 1'b0;
            c_err   <= 1'b0;
            busy    <= 1'b0;
            fail    <= '0;
            rand_q  <= '0;
            for (int k = 0; k < N_RNG; k++) run[k] <= '0;
        end else begin
            rand_q <= rand_in;
            fail   <= fail_nx;
            for (int k = 0; k < N_RNG; k++) run[k] <= run_nx[k];
            case (state)
                IDLE: if (start) begin
                    state <= FILL;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                FILL: begin
                    C   <= c_shift;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state   <= DONE;
                        c_valid <= 1'b1;
                        c_err   <= |fail_nx;
                    end
                end
                DONE: if (c_ready) begin
                    state   <= IDLE;
                    c_valid <= 1'b0;
                    c_err   <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_challenge_gen_hs.sv
// tb_challenge_gen_hs: directed checks of fill order, decorrelation, backpressure,
// stuck detection, async reset and a width sweep.
module tb_challenge_gen_hs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rand4 = '0;
    logic [7:0]  rand8 = '0;
    logic        start = 1'b0;
    logic        c_ready = 1'b0;
    logic [63:0] c0, c1;
    logic [31:0] c2;
    logic [7:0]  c3;
    logic        v0, v1, v2, v3, e0, e1, e2, e3, b0, b1, b2, b3;
    logic [3:0]  f0, f1;
    logic [7:0]  f2, f3;
    int          ncmp = 0;
    int          nfail = 0;

    challenge_gen_hs d0 (.clk(clk), .rst(rst), .rand_in(rand4), .start(start), .c_ready(c_ready),
                         .C(c0), .c_valid(v0), .c_err(e0), .busy(b0), .fail(f0));
    challenge_gen_hs #(.MODE(1)) d1 (.clk(clk), .rst(rst), .rand_in(rand4), .start(start),
                         .c_ready(c_ready), .C(c1), .c_valid(v1), .c_err(e1), .busy(b1), .fail(f1));
    challenge_gen_hs #(.N_CB(32), .N_RNG(8)) d2 (.clk(clk), .rst(rst), .rand_in(rand8), .start(start),
                         .c_ready(c_ready), .C(c2), .c_valid(v2), .c_err(e2), .busy(b2), .fail(f2));
    challenge_gen_hs #(.N_CB(8), .N_RNG(8)) d3 (.clk(clk), .rst(rst), .rand_in(rand8), .start(start),
                         .c_ready(c_ready), .C(c3), .c_valid(v3), .c_err(e3), .busy(b3), .fail(f3));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  base;
        logic [3:0]  step;
        logic [63:0] exp_c;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rand4 = '0;
        rand8 = '0;
        start = 1'b0;
        c_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; leaves d0 just after the completing edge (16 fill shifts).
    task automatic fill4(input logic [3:0] base, input logic [3:0] step, input bit tog);
        start = 1'b1;
        if (tog) rand4 = ~rand4;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", b0, 1);
        for (int i = 0; i < 16; i++) begin
            rand4 = tog ? ~rand4 : 4'(base + step * i);
            @(negedge clk);
            if (i == 14) chk("valid_early", v0, 0);
            if (i == 15) chk("valid_at_w", v0, 1);
        end
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{4'h0, 4'h1, 64'hFEDCBA9876543210};
        vecs[1] = '{4'h0, 4'h0, 64'h0000000000000000};
        vecs[2] = '{4'hF, 4'h0, 64'hFFFFFFFFFFFFFFFF};
        vecs[3] = '{4'h0, 4'hF, 64'h123456789ABCDEF0};
        vecs[4] = '{4'h3, 4'h2, 64'h1FDB97531FDB9753};
        vecs[5] = '{4'h5, 4'h0, 64'h5555555555555555};

        #1;
        chk("rst_C", c0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_err", e0, 0);
        chk("rst_fail", f0, 0);
        @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            fill4(vecs[r].base, vecs[r].step, 1'b0);
            chk($sformatf("vec%0d_C", r), c0, vecs[r].exp_c);
            chk($sformatf("vec%0d_err", r), e0, 0);
            c_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_handshake", r), v0, 0);
            c_ready = 1'b0;
        end

        // Alternating F/0: decorrelated channel sees all ones, raw sees the phase pattern.
        do_reset();
        fill4(4'h0, 4'h0, 1'b1);
        chk("mode1_C", c1, 64'hFFFFFFFFFFFFFFFF);
        chk("mode1_valid", v1, 1);
        chk("mode0_toggle_C", c0, 64'hF0F0F0F0F0F0F0F0);

        // Backpressure: C frozen in DONE, start pulses ignored.
        do_reset();
        fill4(4'h0, 4'h1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rand4 = ~rand4;
            start = i[0];
            @(negedge clk);
            chk("bp_C", c0, 64'hFEDCBA9876543210);
            chk("bp_valid", v0, 1);
            chk("bp_busy", b0, 1);
        end
        start = 1'b1;
        c_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", v0, 0);
        chk("bp_release_busy", b0, 0);
        start = 1'b0;
        c_ready = 1'b0;
        @(negedge clk);
        chk("bp_start_dropped", b0, 0);

        // Channel 2 stuck at 1, others toggling; loop index e is the edge number after reset.
        do_reset();
        c_ready = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            rand4 = e[0] ? 4'b0100 : 4'b1111;
            start = (e == 1 || e == 20);
            @(negedge clk);
            if (e == 17) begin
                chk("stuck_first_valid", v0, 1);
                chk("stuck_first_err", e0, 0);
            end
            if (e == 32) chk("stuck_fail_e32", f0, 4'b0000);
            if (e == 33) chk("stuck_fail_e33", f0, 4'b0100);
            if (e == 36) begin
                chk("stuck_second_valid", v0, 1);
                chk("stuck_second_err", e0, 1);
            end
            if (e == 40) chk("stuck_fail_sticky", f0, 4'b0100);
        end
        start = 1'b0;
        c_ready = 1'b0;

        // Async reset after 5 shifts, checked before any clock edge.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand4 = 4'hA;
            @(negedge clk);
        end
        chk("mid_C_nonzero", c0 != 0, 1);
        rst = 1'b1;
        #1;
        chk("arst_C", c0, 0);
        chk("arst_valid", v0, 0);
        chk("arst_busy", b0, 0);
        chk("arst_fail", f0, 0);
        @(negedge clk);
        rst = 1'b0;
        fill4(4'h0, 4'h1, 1'b0);
        chk("post_rst_C", c0, 64'hFEDCBA9876543210);

        // Width sweep: W=4 and W=1 instances.
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand8 = 8'(8'h11 * (i + 1));
            @(negedge clk);
            if (i == 0) begin
                chk("w1_valid", v3, 1);
                chk("w4_valid_early0", v2, 0);
            end
            if (i == 2) chk("w4_valid_early", v2, 0);
            if (i == 3) begin
                chk("w4_valid", v2, 1);
                chk("w4_C", c2, 32'h44332211);
                chk("w1_C", c3, 8'h11);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
